// File: rtl/guess_scan_ctrl_if.sv
// guess_scan_ctrl_if: guess, word RAM and display signals of the hangman guess sequencer.
interface guess_scan_ctrl_if #(parameter int AW = 4, parameter int CW = 5);
    logic          new_game;
    logic [AW:0]   word_len;
    logic          timeout;
    logic          guess_valid;
    logic [CW-1:0] guess_char;
    logic          guess_ready;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_data;
    logic          fill_valid;
    logic [AW-1:0] fill_addr;
    logic          draw_pulse;
    logic          dup_pulse;
    logic [3:0]    misses;
    logic [AW:0]   remaining;
    logic          win;
    logic          lose;
    modport slave (
        input  new_game, word_len, timeout, guess_valid, guess_char, mem_data,
        output guess_ready, mem_rd, mem_addr, fill_valid, fill_addr, draw_pulse, dup_pulse,
               misses, remaining, win, lose
    );
    modport master (
        output new_game, word_len, timeout, guess_valid, guess_char, mem_data,
        input  guess_ready, mem_rd, mem_addr, fill_valid, fill_addr, draw_pulse, dup_pulse,
               misses, remaining, win, lose
    );
endinterface

// File: rtl/guess_scan_ctrl.sv
// guess_scan_ctrl: scans the word RAM for each guess, issues reveal fills, counts misses,
// and decides win/lose for the hangman round.
module guess_scan_ctrl #(
    parameter int MAX_LEN  = 16,
    parameter int AW       = 4,
    parameter int CW       = 5,
    parameter int MAX_MISS = 9
) (
    input logic clk,
    input logic resetn,
    guess_scan_ctrl_if.slave bus
);
    typedef enum logic [2:0] {OVER, IDLE, SCAN, DRAIN, DECIDE} state_e;
    state_e state_q, state_d;
    logic [AW:0]      len_q, len_d, rem_q, rem_d;
    logic [AW-1:0]    idx_q, idx_d, cmp_addr_q, cmp_addr_d;
    logic [CW-1:0]    char_q, char_d;
    logic [MAX_LEN-1:0] mask_q, mask_d;
    logic [3:0]       miss_q, miss_d, miss_inc;
    logic cmp_v_q, cmp_v_d, hit_q, hit_d, dup_q, dup_d, to_q, to_d;
    logic win_q, win_d, lose_q, lose_d;
    logic match, fresh, draw, dup;
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q    <= OVER;
            len_q      <= '0;
            rem_q      <= '0;
            idx_q      <= '0;
            cmp_addr_q <= '0;
            char_q     <= '0;
            mask_q     <= '0;
            miss_q     <= '0;
            cmp_v_q    <= 1'b0;
            hit_q      <= 1'b0;
            dup_q      <= 1'b0;
            to_q       <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            cmp_addr_q <= cmp_addr_d;
            char_q     <= char_d;
            mask_q     <= mask_d;
            miss_q     <= miss_d;
            cmp_v_q    <= cmp_v_d;
            hit_q      <= hit_d;
            dup_q      <= dup_d;
            to_q       <= to_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        cmp_addr_d = cmp_addr_q;
        char_d     = char_q;
        mask_d     = mask_q;
        miss_d     = miss_q;
        cmp_v_d    = 1'b0;
        hit_d      = hit_q;
        dup_d      = dup_q;
        to_d       = to_q;
        win_d      = win_q;
        lose_d     = lose_q;
        draw       = 1'b0;
        dup        = 1'b0;
        match      = cmp_v_q && bus.mem_data == char_q;
        fresh      = match && !mask_q[cmp_addr_q];
        miss_inc   = miss_q == 4'(MAX_MISS) ? miss_q : miss_q + 4'd1;
        // compare stage runs one cycle behind the read issued in SCAN
        if (fresh) begin
            mask_d[cmp_addr_q] = 1'b1;
            rem_d = rem_q - 1'b1;
            hit_d = 1'b1;
        end
        if (match && !fresh)
            dup_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (rem_q == '0) begin
                    win_d   = 1'b1;
                    state_d = OVER;
                end else if (bus.timeout) begin
                    lose_d  = 1'b1;
                    state_d = OVER;
                end else if (bus.guess_valid) begin
                    char_d  = bus.guess_char;
                    idx_d   = '0;
                    hit_d   = 1'b0;
                    dup_d   = 1'b0;
                    to_d    = 1'b0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                cmp_v_d    = 1'b1;
                cmp_addr_d = idx_q;
                idx_d      = idx_q + 1'b1;
                to_d       = to_q | bus.timeout;
                if ({1'b0, idx_q} == len_q - 1'b1)
                    state_d = DRAIN;
            end
            DRAIN: begin
                to_d    = to_q | bus.timeout;
                state_d = DECIDE;
            end
            DECIDE: begin
                state_d = IDLE;
                if (hit_q && rem_q == '0) begin
                    win_d   = 1'b1;
                    state_d = OVER;
                end else begin
                    dup  = !hit_q && dup_q;
                    draw = !hit_q && !dup_q;
                    if (draw)
                        miss_d = miss_inc;
                    if (to_q || bus.timeout || (draw && miss_inc == 4'(MAX_MISS))) begin
                        lose_d  = 1'b1;
                        state_d = OVER;
                    end
                end
            end
            default: ;
        endcase
        if (bus.new_game) begin
            len_d   = bus.word_len > (AW+1)'(MAX_LEN) ? (AW+1)'(MAX_LEN) : bus.word_len;
            rem_d   = len_d;
            idx_d   = '0;
            mask_d  = '0;
            miss_d  = '0;
            cmp_v_d = 1'b0;
            hit_d   = 1'b0;
            dup_d   = 1'b0;
            to_d    = 1'b0;
            win_d   = 1'b0;
            lose_d  = 1'b0;
            state_d = IDLE;
        end
    end
    assign bus.guess_ready = state_q == IDLE && rem_q != '0;
    assign bus.mem_rd      = state_q == SCAN;
    assign bus.mem_addr    = idx_q;
    assign bus.fill_valid  = fresh;
    assign bus.fill_addr   = cmp_addr_q;
    assign bus.draw_pulse  = draw;
    assign bus.dup_pulse   = dup;
    assign bus.misses      = miss_q;
    assign bus.remaining   = rem_q;
    assign bus.win         = win_q;
    assign bus.lose        = lose_q;
endmodule

// File: tb/tb_guess_scan_ctrl.sv
// tb_guess_scan_ctrl: directed rounds with a word/mask model; expected fill addresses
// are queued at guess time and popped as the DUT issues fills.
module tb_guess_scan_ctrl;
    localparam int AW = 4;
    localparam int CW = 5;
    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;
    guess_scan_ctrl_if #(.AW(AW), .CW(CW)) bus();
    guess_scan_ctrl #(.MAX_LEN(16), .AW(AW), .CW(CW), .MAX_MISS(9)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );
    logic [CW-1:0] ram [16];
    int  checks = 0;
    int  errors = 0;
    int  exp_q[$];
    byte word_m [16];
    bit  mask_m [16];
    int  len_m, rem_m, miss_m;
    bit  win_m, lose_m;

    function automatic logic [CW-1:0] code(input byte ch);
        return CW'(int'(ch) - 64);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) if (bus.mem_rd) bus.mem_data <= ram[bus.mem_addr];

    always @(negedge clk) begin
        if (!resetn && bus.fill_valid) begin
            if (exp_q.size() == 0) chk("fill_unexpected", 32'(bus.fill_addr), 32'hFFFF);
            else chk("fill_addr", 32'(bus.fill_addr), 32'(exp_q.pop_front()));
        end
    end

    task automatic newgame(input string w, input int len);
        for (int i = 0; i < 16; i++) begin
            ram[i]    = i < w.len() ? code(w[i]) : '0;
            word_m[i] = i < w.len() ? w[i] : 8'd0;
            mask_m[i] = 1'b0;
        end
        len_m = len > 16 ? 16 : len;
        rem_m = len_m;
        miss_m = 0;
        win_m = 1'b0;
        lose_m = 1'b0;
        exp_q.delete();
        bus.new_game = 1'b1;
        bus.word_len = 5'(len);
        tick;
        bus.new_game = 1'b0;
    endtask

    task automatic guess(input byte ch, input bit to);
        int n;
        bit hit, dp;
        n = 0;
        while (!bus.guess_ready && n < 50) begin tick; n++; end
        chk("ready_before_guess", bus.guess_ready, 1);
        hit = 1'b0;
        dp = 1'b0;
        for (int i = 0; i < len_m; i++) begin
            if (word_m[i] == ch) begin
                if (!mask_m[i]) begin
                    exp_q.push_back(i);
                    mask_m[i] = 1'b1;
                    rem_m--;
                    hit = 1'b1;
                end else dp = 1'b1;
            end
        end
        bus.guess_valid = 1'b1;
        bus.guess_char = code(ch);
        tick;
        bus.guess_valid = 1'b0;
        chk("mem_rd_first", bus.mem_rd, 1);
        chk("mem_addr_first", 32'(bus.mem_addr), 0);
        bus.timeout = to;
        tick;
        bus.timeout = 1'b0;
        repeat (len_m) tick;
        chk("decide_ready", bus.guess_ready, 0);
        chk("draw_pulse", bus.draw_pulse, 32'(!hit && !dp));
        chk("dup_pulse", bus.dup_pulse, 32'(!hit && dp));
        tick;
        if (hit && rem_m == 0) win_m = 1'b1;
        else begin
            if (!hit && !dp) miss_m++;
            if (to || miss_m == 9) lose_m = 1'b1;
        end
        chk("fills_done", 32'(exp_q.size()), 0);
        chk("remaining", 32'(bus.remaining), 32'(rem_m));
        chk("misses", 32'(bus.misses), 32'(miss_m));
        chk("win", bus.win, 32'(win_m));
        chk("lose", bus.lose, 32'(lose_m));
        chk("ready_after", bus.guess_ready, 32'(!(win_m || lose_m)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        byte misses_seq [9] = '{"X", "Y", "Z", "Q", "W", "V", "U", "J", "K"};
        bus.new_game = 1'b0;
        bus.word_len = '0;
        bus.timeout = 1'b0;
        bus.guess_valid = 1'b0;
        bus.guess_char = '0;
        bus.mem_data = '0;
        repeat (3) tick;
        chk("rst_ready", bus.guess_ready, 0);
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_fill", bus.fill_valid, 0);
        chk("rst_pulses", {bus.draw_pulse, bus.dup_pulse}, 0);
        chk("rst_win_lose", {bus.win, bus.lose}, 0);
        chk("rst_addrs", {bus.mem_addr, bus.fill_addr}, 0);
        chk("rst_counts", {bus.misses, bus.remaining}, 0);
        resetn = 1'b0;
        tick;
        chk("over_no_ready", bus.guess_ready, 0);
        // CAT / A
        newgame("CAT", 3);
        chk("cat_remaining", 32'(bus.remaining), 3);
        guess("A", 1'b0);
        // BOOK / O twice
        newgame("BOOK", 4);
        guess("O", 1'b0);
        guess("O", 1'b0);
        // DOG / nine misses
        newgame("DOG", 3);
        foreach (misses_seq[i]) guess(misses_seq[i], 1'b0);
        bus.guess_valid = 1'b1;
        bus.guess_char = code("D");
        bus.timeout = 1'b1;
        repeat (3) begin
            tick;
            chk("over_ready", bus.guess_ready, 0);
            chk("over_mem_rd", bus.mem_rd, 0);
        end
        bus.guess_valid = 1'b0;
        bus.timeout = 1'b0;
        chk("over_lose_holds", {bus.win, bus.lose}, 1);
        // HI with timeout during the winning scan
        newgame("HI", 2);
        guess("H", 1'b0);
        guess("I", 1'b1);
        // timeout while idle
        newgame("CAT", 3);
        bus.timeout = 1'b1;
        tick;
        bus.timeout = 1'b0;
        chk("idle_to_lose", bus.lose, 1);
        chk("idle_to_win", bus.win, 0);
        chk("idle_to_ready", bus.guess_ready, 0);
        // reset mid-scan
        newgame("CAT", 3);
        guess("Z", 1'b0);
        bus.guess_valid = 1'b1;
        bus.guess_char = code("Q");
        tick;
        bus.guess_valid = 1'b0;
        tick;
        resetn = 1'b1;
        #1;
        chk("midrst_mem_rd", bus.mem_rd, 0);
        chk("midrst_ready", bus.guess_ready, 0);
        chk("midrst_counts", {bus.misses, bus.remaining}, 0);
        chk("midrst_win_lose", {bus.win, bus.lose}, 0);
        tick;
        resetn = 1'b0;
        tick;
        chk("midrst_over", bus.guess_ready, 0);
        // new_game mid-scan
        newgame("CAT", 3);
        guess("Z", 1'b0);
        bus.guess_valid = 1'b1;
        bus.guess_char = code("C");
        tick;
        bus.guess_valid = 1'b0;
        newgame("CAT", 3);
        chk("ng_misses", 32'(bus.misses), 0);
        chk("ng_remaining", 32'(bus.remaining), 3);
        chk("ng_ready", bus.guess_ready, 1);
        repeat (4) tick;
        guess("C", 1'b0);
        guess("C", 1'b0);
        // empty word wins at once
        newgame("", 0);
        tick;
        chk("len0_win", bus.win, 1);
        chk("len0_lose", bus.lose, 0);
        chk("len0_remaining", 32'(bus.remaining), 0);
        chk("len0_ready", bus.guess_ready, 0);
        // oversize length clamps to 16
        newgame("ABCDEFGHIJKLMNOP", 20);
        chk("len20_remaining", 32'(bus.remaining), 16);
        guess("P", 1'b0);
        guess("A", 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/guess_scan_ctrl.md
# guess_scan_ctrl

Sequencer for the guess-evaluation datapath of the hangman game. It accepts one guessed character at a time and scans the stored word memory position by position. For each newly matched position it issues a fill command to the display path, and it tracks the remaining blanks and the miss count. It raises win/lose when the round ends. It sits between the keyboard/guess front end, the word RAM and the blank-fill/part-draw display logic.

## Interface
- MAX_LEN, 16: maximum word length in characters.
- AW, 4: word memory address width (2^AW >= MAX_LEN).
- CW, 5: character code width.
- MAX_MISS, 9: miss count that ends the round as lost (one per hangman part).
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  reset, asynchronous, active-high.
- new_game  in  1  one-cycle pulse; starts a round and samples word_len.
- word_len  in  AW+1  number of stored characters; sampled only on new_game.
- timeout  in  1  round timer expiry pulse.
- guess_valid  in  1  guess offered.
- guess_char  in  CW  guessed character.
- guess_ready  out  1  block can accept a guess.
- mem_rd  out  1  word RAM read strobe.
- mem_addr  out  AW  word RAM address.
- mem_data  in  CW  RAM read data, valid the cycle after mem_rd.
- fill_valid  out  1  one-cycle pulse per newly revealed position.
- fill_addr  out  AW  position to reveal; qualified by fill_valid.
- draw_pulse  out  1  one-cycle pulse per miss; advances the part drawer.
- dup_pulse  out  1  one-cycle pulse; guess matched only already-revealed positions.
- misses  out  4  misses in the current round.
- remaining  out  AW+1  unrevealed positions.
- win, lose  out  1 each  sticky until the next new_game or reset.

## Operation
- States: OVER (reset state, no round active), IDLE, SCAN, DRAIN, DECIDE.
- new_game acts in any state and overrides every other input. On new_game:
  - clear the reveal mask, misses, win, lose and the pipeline;
  - set remaining = min(word_len, MAX_LEN);
  - go to IDLE.
- word_len = 0 gives remaining = 0. The block enters OVER with win = 1 one cycle later.
- guess_ready = 1 only in IDLE.
- Accept: guess_valid & guess_ready at an edge. Latch guess_char, set idx = 0, go to SCAN.
- SCAN, one cycle per index:
  - mem_rd = 1, mem_addr = idx, idx increments;
  - after issuing idx = len-1, go to DRAIN.
- Compare stage, pipelined one cycle behind issue. In the cycle mem_data is valid for address p:
  - if mem_data == latched char and mask[p] = 0: assert fill_valid with fill_addr = p; at the edge set mask[p], decrement remaining and increment the hit count;
  - if mem_data == latched char and mask[p] = 1: set the dup flag only.
- DRAIN: no read issued; compares the last address. Then go to DECIDE.
- DECIDE, one cycle:
  - hits > 0 and remaining == 0: win = 1, go to OVER.
  - hits > 0 and remaining != 0: go to IDLE.
  - hits == 0 with dup flag set: dup_pulse, no penalty, go to IDLE.
  - hits == 0 with no dup flag: draw_pulse and misses + 1. If the new misses == MAX_MISS, lose = 1 and go to OVER; else go to IDLE.
- timeout:
  - in IDLE: lose = 1, go to OVER next edge;
  - in SCAN or DRAIN: latched, then applied in DECIDE after the win check. A guess that completes the word still wins.
- OVER: no guesses, no reads, outputs hold. timeout is ignored.
- misses saturates at MAX_MISS. remaining never underflows, because each position can be revealed only once.

## Timing
- Reset values:
  - state OVER;
  - guess_ready, mem_rd, fill_valid, draw_pulse, dup_pulse, win, lose all 0;
  - mem_addr, fill_addr, misses, remaining all 0;
  - mask cleared.
- Guess accepted at edge t:
  - mem_rd is high in cycles t+1 … t+len;
  - fill pulses fall in t+2 … t+len+1;
  - DECIDE is cycle t+len+2;
  - guess_ready returns at t+len+3, unless the round ended.
- draw_pulse, dup_pulse, win and lose all change in the DECIDE cycle or at the edge that ends it. win and lose are registered.
- A guess_valid held high through the scan is not re-accepted until guess_ready is 1.

## Test plan
- Word "CAT", len 3, guess 'A' -> one fill_valid with fill_addr = 1; remaining 3→2; no draw_pulse; guess_ready back 6 cycles after accept.
- Word "BOOK", guess 'O' twice -> first guess: fills at addr 1 and 2, remaining 4→2. Second guess: dup_pulse, misses stays 0.
- Word "DOG", guesses X,Y,Z,... with MAX_MISS = 9 -> 9 draw_pulses; lose = 1 after the 9th; guess_ready stays 0 afterwards.
- Word "HI": guess 'H', then guess 'I' with timeout pulsed during the SCAN of 'I' -> win = 1, lose = 0.
- Reset asserted mid-SCAN -> all outputs 0 immediately and state OVER. new_game mid-scan -> mask, misses and remaining reinitialised, next guess accepted normally.
- word_len = 0 on new_game -> win = 1 next cycle; word_len = 20 -> remaining = 16.
